// File: rtl/add_multi_acc.sv
// Streaming multi-input adder: a balanced pipelined tree reduces N addends per beat,
// and the per-beat sums are folded into an accumulator over beats delimited by ilast.
module add_multi_acc #(
  parameter int N         = 8,
  parameter int ARG_WIDTH = 8,
  parameter int SIGNED    = 0,
  parameter int DEPTH     = 2,
  parameter int ACC_WIDTH = 24,
  parameter int BIAS_EN   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ivld,
  output logic                 irdy,
  input  logic                 ilast,
  input  logic [ARG_WIDTH-1:0] iarg [N],
  input  logic [ACC_WIDTH-1:0] ibias,
  output logic                 ovld,
  input  logic                 ordy,
  output logic [ACC_WIDTH-1:0] osum,
  output logic [15:0]          ocnt
);

  localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
  localparam int NP     = 1 << LEVELS;
  localparam int D      = (DEPTH < LEVELS) ? DEPTH : LEVELS;
  localparam int TW     = ARG_WIDTH + LEVELS;

  logic adv, accept, first;

  assign adv    = !ovld || ordy;
  assign irdy   = adv;
  assign accept = ivld && adv;

  // Each level carries its node values plus a valid/last/first/bias shadow so the
  // accumulator sees per-beat control aligned with the tree output.
  for (genvar L = 0; L <= LEVELS; L++) begin : lvl
    localparam int CNT = NP >> L;
    logic [TW-1:0]        node [CNT];
    logic                 v, l, f;
    logic [ACC_WIDTH-1:0] b;

    if (L == 0) begin : g_leaf
      for (genvar i = 0; i < NP; i++) begin : g_in
        if (i >= N) begin : g_pad
          assign node[i] = '0;
        end else if (SIGNED != 0) begin : g_sx
          assign node[i] = TW'(signed'(iarg[i]));
        end else begin : g_zx
          assign node[i] = TW'(iarg[i]);
        end
      end
      assign v = accept;
      assign l = ilast;
      assign f = first;
      assign b = ibias;
    end else begin : g_node
      localparam bit REG = ((L * D) / LEVELS) > (((L - 1) * D) / LEVELS);
      logic [TW-1:0] s [CNT];

      always_comb begin
        for (int j = 0; j < CNT; j++) s[j] = lvl[L-1].node[2*j] + lvl[L-1].node[2*j+1];
      end

      if (REG) begin : g_reg
        always_ff @(posedge clk) begin
          if (rst) v <= 1'b0;
          else if (adv) v <= lvl[L-1].v;
          if (adv) begin
            node <= s;
            l    <= lvl[L-1].l;
            f    <= lvl[L-1].f;
            b    <= lvl[L-1].b;
          end
        end
      end else begin : g_comb
        assign node = s;
        assign v    = lvl[L-1].v;
        assign l    = lvl[L-1].l;
        assign f    = lvl[L-1].f;
        assign b    = lvl[L-1].b;
      end
    end
  end

  logic [ACC_WIDTH-1:0] tree_ext, seed, base, acc, acc_nxt;
  logic [15:0]          cnt, cnt_nxt;
  logic                 rv, rl, rf;

  if (SIGNED != 0) begin : g_root_sx
    assign tree_ext = ACC_WIDTH'(signed'(lvl[LEVELS].node[0]));
  end else begin : g_root_zx
    assign tree_ext = ACC_WIDTH'(lvl[LEVELS].node[0]);
  end

  assign rv = lvl[LEVELS].v;
  assign rl = lvl[LEVELS].l;
  assign rf = lvl[LEVELS].f;

  always_comb begin
    seed    = lvl[LEVELS].b & {ACC_WIDTH{BIAS_EN != 0}};
    base    = rf ? seed : acc;
    acc_nxt = base + tree_ext;
    cnt_nxt = rf ? 16'd1 : ((cnt == 16'hFFFF) ? cnt : cnt + 16'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first <= 1'b1;
      acc   <= '0;
      cnt   <= '0;
      ovld  <= 1'b0;
      osum  <= '0;
      ocnt  <= '0;
    end else begin
      if (accept) first <= ilast;
      if (adv) begin
        // A handshake with a new result arriving simply replaces the old one.
        ovld <= rv && rl;
        if (rv) begin
          acc <= acc_nxt;
          cnt <= cnt_nxt;
          if (rl) begin
            osum <= acc_nxt;
            ocnt <= cnt_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_add_multi_acc.sv
// Directed bench: an unsigned DEPTH=2 instance and a signed/biased DEPTH=1 instance share stimulus.
module tb_add_multi_acc;

  logic        clk = 1'b0;
  logic        rst, ivld, ilast, ordy;
  logic [3:0]  iarg [4];
  logic [23:0] ibias;
  logic        irdy_u, ovld_u, irdy_s, ovld_s;
  logic [23:0] osum_u, osum_s;
  logic [15:0] ocnt_u, ocnt_s;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { logic [23:0] sum; logic [15:0] cnt; int cyc; } res_t;
  res_t q_u[$], q_s[$], e_u[$], e_s[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  add_multi_acc #(.N(4), .ARG_WIDTH(4), .SIGNED(0), .DEPTH(2), .ACC_WIDTH(24), .BIAS_EN(0)) dut_u (
    .clk(clk), .rst(rst), .ivld(ivld), .irdy(irdy_u), .ilast(ilast), .iarg(iarg),
    .ibias(ibias), .ovld(ovld_u), .ordy(ordy), .osum(osum_u), .ocnt(ocnt_u));

  add_multi_acc #(.N(4), .ARG_WIDTH(4), .SIGNED(1), .DEPTH(1), .ACC_WIDTH(24), .BIAS_EN(1)) dut_s (
    .clk(clk), .rst(rst), .ivld(ivld), .irdy(irdy_s), .ilast(ilast), .iarg(iarg),
    .ibias(ibias), .ovld(ovld_s), .ordy(ordy), .osum(osum_s), .ocnt(ocnt_s));

  // Results are collected where the handshake happens; inputs change only just after posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ovld_u && ordy) q_u.push_back('{osum_u, ocnt_u, cyc});
      if (ovld_s && ordy) q_s.push_back('{osum_s, ocnt_s, cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] a0, a1, a2, a3, input logic last, input logic [23:0] b);
    ivld = 1'b1; ilast = last; ibias = b;
    iarg[0] = a0; iarg[1] = a1; iarg[2] = a2; iarg[3] = a3;
    tick();
  endtask

  task automatic idle();
    ivld = 1'b0; ilast = 1'b0;
  endtask

  task automatic expect_both(input logic [23:0] su, input logic [23:0] ss, input logic [15:0] c);
    e_u.push_back('{su, c, 0});
    e_s.push_back('{ss, c, 0});
  endtask

  initial begin
    int k0, nu, ns;
    rst = 1'b1; ivld = 1'b0; ilast = 1'b0; ordy = 1'b1; ibias = '0;
    for (int i = 0; i < 4; i++) iarg[i] = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ovld_u", ovld_u, 1'b0);
    chk("rst_osum_u", osum_u, 24'd0);
    chk("rst_ocnt_u", ocnt_u, 16'd0);
    chk("rst_irdy_u", irdy_u, 1'b1);
    chk("rst_ovld_s", ovld_s, 1'b0);

    // single beat, latency D+1
    beat(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 24'd0);
    idle();
    chk("lat_u_c1", ovld_u, 1'b0);
    tick();
    chk("lat_u_c2", ovld_u, 1'b0);
    chk("lat_s_vld", ovld_s, 1'b1);
    chk("lat_s_sum", osum_s, 24'd10);
    tick();
    chk("lat_u_vld", ovld_u, 1'b1);
    chk("lat_u_sum", osum_u, 24'd10);
    chk("lat_u_cnt", ocnt_u, 16'd1);
    expect_both(24'd10, 24'd10, 16'd1);
    repeat (3) tick();

    // 3-beat fold then 2-beat fold, back to back
    k0 = q_u.size();
    repeat (2) beat(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 24'd0);
    beat(4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 24'd0);
    beat(4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 24'd0);
    beat(4'd1, 4'd1, 4'd1, 4'd1, 1'b1, 24'd0);
    idle();
    expect_both(24'd180, 24'hFFFFF4, 16'd3);
    expect_both(24'd8, 24'd8, 16'd2);
    repeat (5) tick();
    if (q_u.size() >= k0 + 2) chk("no_bubble_gap", q_u[k0+1].cyc - q_u[k0].cyc, 2);
    else chk("no_bubble_cnt", q_u.size() - k0, 2);

    // signed fold
    beat(4'd8, 4'd7, 4'd15, 4'd0, 1'b0, 24'd0);
    beat(4'd8, 4'd8, 4'd8, 4'd8, 1'b1, 24'd0);
    idle();
    expect_both(24'd62, 24'hFFFFDE, 16'd2);
    repeat (5) tick();

    // bias seeded on first beat only
    beat(4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 24'd100);
    beat(4'd2, 4'd2, 4'd2, 4'd2, 1'b1, 24'd55);
    idle();
    expect_both(24'd12, 24'd112, 16'd2);
    repeat (5) tick();

    // backpressure
    ordy = 1'b0;
    beat(4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 24'd0);
    idle();
    for (int k = 0; k < 10 && !(ovld_u && ovld_s); k++) tick();
    chk("bp_pending", {ovld_u, ovld_s}, 2'b11);
    ivld = 1'b1; ilast = 1'b1;
    for (int i = 0; i < 4; i++) iarg[i] = 4'd5;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_irdy_u", irdy_u, 1'b0);
      chk("bp_irdy_s", irdy_s, 1'b0);
      chk("bp_ovld_u", ovld_u, 1'b1);
      chk("bp_osum_u", osum_u, 24'd12);
      chk("bp_osum_s", osum_s, 24'd12);
    end
    ordy = 1'b1;
    tick();
    idle();
    expect_both(24'd12, 24'd12, 16'd1);
    expect_both(24'd20, 24'd20, 16'd1);
    repeat (5) tick();

    // reset mid-fold
    beat(4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 24'd0);
    beat(4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 24'd0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ovld_u", ovld_u, 1'b0);
    chk("mid_rst_ovld_s", ovld_s, 1'b0);
    tick();
    beat(4'd1, 4'd1, 4'd1, 4'd1, 1'b1, 24'd0);
    idle();
    expect_both(24'd4, 24'd4, 16'd1);
    repeat (6) tick();

    chk("res_count_u", q_u.size(), e_u.size());
    chk("res_count_s", q_s.size(), e_s.size());
    nu = (q_u.size() < e_u.size()) ? q_u.size() : e_u.size();
    ns = (q_s.size() < e_s.size()) ? q_s.size() : e_s.size();
    for (int i = 0; i < nu; i++) begin
      chk($sformatf("sum_u[%0d]", i), q_u[i].sum, e_u[i].sum);
      chk($sformatf("cnt_u[%0d]", i), q_u[i].cnt, e_u[i].cnt);
    end
    for (int i = 0; i < ns; i++) begin
      chk($sformatf("sum_s[%0d]", i), q_s[i].sum, e_s[i].sum);
      chk($sformatf("cnt_s[%0d]", i), q_s[i].cnt, e_s[i].cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
